// File: rtl/ring_interlock_pkg.sv
// Shared types and width helpers for the ring interlock controller.
package ring_interlock_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FB = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    // Kind of contactor operation being granted.
    typedef enum logic {
        OP_OPEN  = 1'b0,
        OP_CLOSE = 1'b1
    } op_e;

    // Bits needed to index one of n contactors (at least 1).
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ring_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module ring_prio_enc
    import ring_interlock_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = id_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_valid_c,
    output logic [IDX_W-1:0] o_idx_c
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_valid_c = 1'b0;
        o_idx_c   = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_valid_c = 1'b1;
                o_idx_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_interlock_ctrl.sv
// Ring contactor interlock controller: grants one open/close at a time,
// confirms it against feedback within a timeout, and refuses any close that
// would exceed MAX_CLOSED contactors. Define RING_INTERLOCK_FB_SYNC_EN to put
// a 2-flop synchroniser on every feedback bit before it is used.
module ring_interlock_ctrl
    import ring_interlock_pkg::*;
#(
    parameter  int unsigned N_CONTACTORS   = 8,
    parameter  int unsigned MAX_CLOSED     = N_CONTACTORS - 1,
    parameter  int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned ID_W           = id_width(N_CONTACTORS),
    localparam int unsigned CNT_W          = cnt_width(N_CONTACTORS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_CONTACTORS-1:0] i_req_close,
    input  logic [N_CONTACTORS-1:0] i_req_open,
    input  logic [N_CONTACTORS-1:0] i_fb,
    input  logic                    i_fault_clr,
    output logic [N_CONTACTORS-1:0] o_cmd,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_deny,
    output logic [ID_W-1:0]         o_op_id,
    output logic                    o_fault,
    output logic [CNT_W-1:0]        o_closed_cnt
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned N       = N_CONTACTORS;

    state_e            r_state;
    logic [N-1:0]      r_cmd;
    logic [ID_W-1:0]   r_op_id;
    logic [TIMER_W-1:0] r_timer;
    logic              r_done;
    logic              r_deny;
    logic              r_busy;
    logic              r_fault;

    state_e            w_state_nxt;
    logic [N-1:0]      w_cmd_nxt;
    logic [ID_W-1:0]   w_op_id_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic              w_done_nxt;
    logic              w_deny_nxt;

    logic [N-1:0]      w_fb;
    logic [N-1:0]      w_open_pend;
    logic [N-1:0]      w_close_pend;
    logic              w_open_vld;
    logic              w_close_vld;
    logic [ID_W-1:0]   w_open_idx;
    logic [ID_W-1:0]   w_close_idx;
    logic [CNT_W-1:0]  w_closed_cnt;
    logic              w_close_ok;
    logic              w_mis_any;
    logic [ID_W-1:0]   w_mis_idx;
    op_e               w_op_type;
    logic [ID_W-1:0]   w_grant_idx;

`ifdef RING_INTERLOCK_FB_SYNC_EN
    logic [N-1:0] r_fb_meta;
    logic [N-1:0] r_fb_sync;

    // Two-flop synchroniser on the asynchronous auxiliary contacts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fb_meta <= '0;
            r_fb_sync <= '0;
        end else begin
            r_fb_meta <= i_fb;
            r_fb_sync <= r_fb_meta;
        end
    end

    assign w_fb = r_fb_sync;
`else
    assign w_fb = i_fb;
`endif

    // Requests that would actually change a contactor; an open request on
    // the same contactor suppresses its close so open always wins.
    assign w_open_pend  = i_req_open & r_cmd;
    assign w_close_pend = i_req_close & ~r_cmd & ~i_req_open;

    ring_prio_enc #(.WIDTH(N)) u_open_enc (
        .i_vec     (w_open_pend),
        .o_valid_c (w_open_vld),
        .o_idx_c   (w_open_idx)
    );

    ring_prio_enc #(.WIDTH(N)) u_close_enc (
        .i_vec     (w_close_pend),
        .o_valid_c (w_close_vld),
        .o_idx_c   (w_close_idx)
    );

    // Popcount of confirmed-closed contactors used by the interlock rule.
    always_comb begin
        w_closed_cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_closed_cnt = w_closed_cnt + CNT_W'(w_fb[i]);
        end
    end

    // Lowest contactor whose feedback disagrees with its command.
    always_comb begin
        w_mis_any = 1'b0;
        w_mis_idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_fb[i] != r_cmd[i]) begin
                w_mis_any = 1'b1;
                w_mis_idx = ID_W'(i);
            end
        end
    end

    assign w_close_ok  = (32'(w_closed_cnt) + 32'd1) <= 32'(MAX_CLOSED);
    assign w_op_type   = w_open_vld ? OP_OPEN : OP_CLOSE;
    assign w_grant_idx = w_open_vld ? w_open_idx : w_close_idx;

    // Next-state, command and pulse logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_op_id_nxt = r_op_id;
        w_timer_nxt = r_timer;
        w_done_nxt  = 1'b0;
        w_deny_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_mis_any) begin
                    w_state_nxt = ST_FAULT;
                    w_op_id_nxt = w_mis_idx;
                    w_cmd_nxt   = '0;
                end else if (w_open_vld || w_close_vld) begin
                    w_op_id_nxt = w_grant_idx;
                    if (w_op_type == OP_CLOSE && !w_close_ok) begin
                        w_deny_nxt = 1'b1;
                    end else begin
                        w_cmd_nxt[w_grant_idx] = (w_op_type == OP_CLOSE);
                        w_timer_nxt            = '0;
                        w_state_nxt            = ST_WAIT_FB;
                    end
                end
            end
            ST_WAIT_FB: begin
                if (w_fb[r_op_id] == r_cmd[r_op_id]) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = ST_FAULT;
                    w_cmd_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            ST_FAULT: begin
                w_cmd_nxt = '0;
                if (i_fault_clr && (w_fb == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cmd_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_op_id <= '0;
            r_timer <= '0;
            r_done  <= 1'b0;
            r_deny  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_op_id <= w_op_id_nxt;
            r_timer <= w_timer_nxt;
            r_done  <= w_done_nxt;
            r_deny  <= w_deny_nxt;
            r_busy  <= (w_state_nxt == ST_WAIT_FB);
            r_fault <= (w_state_nxt == ST_FAULT);
        end
    end

    assign o_cmd        = r_cmd;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_deny       = r_deny;
    assign o_op_id      = r_op_id;
    assign o_fault      = r_fault;
    assign o_closed_cnt = w_closed_cnt;

endmodule
